// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers: pointer width, Gray/binary conversion, read status record.
// Pure package; no latency or flow control of its own.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  typedef struct packed {
    logic empty;
    logic underflow;
  } rd_stat_t;

  // One extra bit beyond the RAM address separates "full lap" from "empty".
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// N-flop synchronizer for a Gray-coded bus; latency STAGES clk edges.
// No backpressure: samples d every edge.
module sync_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rd_ctrl_gray.sv
// Async-FIFO read-side controller; flags lag wptr_gray by SYNC_STAGES+1 rclk edges.
// Reads are refused while empty (runderflow pulse). Level tracking only with RD_CTRL_LEVEL_EN.
module rd_ctrl_gray
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4,
  localparam int PW           = ptr_width(ADDR_WIDTH)
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [PW-1:0]         wptr_gray,
  output logic [PW-1:0]         rptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [PW-1:0]         rlevel,
  output logic                  runderflow
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > (2 ** ADDR_WIDTH)) begin : g_bad_param
    $error("rd_ctrl_gray: SYNC_STAGES or AEMPTY_THRESH out of range");
  end

  logic [PW-1:0] wq_gray;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic          rd_en;
  rd_stat_t      stat_q;
  rd_stat_t      stat_d;

  sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr_gray),
    .q     (wq_gray)
  );

  assign rd_en      = rinc & ~stat_q.empty;
  assign rbin_next  = rbin + PW'(rd_en);
  assign rgray_next = PW'(bin2gray(ptr_max_t'(rbin_next)));

  // Empty is judged against the pointer this edge will publish, so a
  // read that drains the last word raises rempty on the same edge.
  always_comb begin
    stat_d           = '0;
    stat_d.empty     = (rgray_next == wq_gray);
    stat_d.underflow = rinc & stat_q.empty;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      stat_q    <= '{empty: 1'b1, underflow: 1'b0};
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      stat_q    <= stat_d;
    end
  end

  assign raddr      = rbin[ADDR_WIDTH-1:0];
  assign rempty     = stat_q.empty;
  assign runderflow = stat_q.underflow;

`ifdef RD_CTRL_LEVEL_EN
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] level_next;

  assign wq_bin     = PW'(gray2bin(ptr_max_t'(wq_gray)));
  assign level_next = wq_bin - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel  <= '0;
      raempty <= 1'b1;
    end else begin
      rlevel  <= level_next;
      raempty <= (ptr_max_t'(level_next) <= ptr_max_t'(AEMPTY_THRESH));
    end
  end
`else
  assign rlevel  = '0;
  assign raempty = stat_q.empty;
`endif

endmodule

// File: tb/tb_rd_ctrl_gray.sv
// Bench for rd_ctrl_gray: directed reset/latency/level/underflow steps, then random streaming
// across pointer wrap, checked against a write/read count model with a sync-delay history.
module tb_rd_ctrl_gray;

  localparam int AW = 4;
  localparam int PW = 5;
  localparam int SS = 2;
  localparam int TH = 2;
`ifdef RD_CTRL_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic          rinc = 1'b0;
  logic [PW-1:0] wptr_gray = '0;
  logic [PW-1:0] rptr_gray;
  logic [AW-1:0] raddr;
  logic          rempty;
  logic          raempty;
  logic [PW-1:0] rlevel;
  logic          runderflow;

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  // Model: total writes issued, total reads accepted, write counts seen per edge.
  int wcnt;
  int rcnt;
  int m_level;
  bit m_empty;
  bit m_under;
  int hist[$];

  always #5 rclk = ~rclk;

  rd_ctrl_gray #(
    .ADDR_WIDTH    (AW),
    .SYNC_STAGES   (SS),
    .AEMPTY_THRESH (TH)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rinc       (rinc),
    .wptr_gray  (wptr_gray),
    .rptr_gray  (rptr_gray),
    .raddr      (raddr),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel),
    .runderflow (runderflow)
  );

  function automatic logic [PW-1:0] gray_of(input int n);
    int b;
    b = n & 31;
    return PW'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wcnt    = 0;
    rcnt    = 0;
    m_level = 0;
    m_empty = 1'b1;
    m_under = 1'b0;
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/rempty"},     32'(rempty),     32'(m_empty));
    chk({tag, "/raempty"},    32'(raempty),    LEVEL_EN ? 32'(m_level <= TH) : 32'(m_empty));
    chk({tag, "/rlevel"},     32'(rlevel),     LEVEL_EN ? 32'(m_level) : 32'd0);
    chk({tag, "/raddr"},      32'(raddr),      32'(rcnt % 16));
    chk({tag, "/rptr_gray"},  32'(rptr_gray),  32'(gray_of(rcnt)));
    chk({tag, "/runderflow"}, 32'(runderflow), 32'(m_under));
  endtask

  // One rclk cycle: drive at negedge, advance model at posedge, check 1ns later.
  task automatic cyc(input bit ri, input bit wadv);
    @(negedge rclk);
    rinc = ri;
    if (wadv) wcnt++;
    wptr_gray = gray_of(wcnt);
    @(posedge rclk);
    m_under = ri && m_empty;
    if (ri && !m_empty) rcnt++;
    m_level = hist[0] - rcnt;
    m_empty = (m_level == 0);
    hist.push_back(wcnt);
    void'(hist.pop_front());
    #1;
    check_all("cyc");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            gray_wraps;
    int            addr_wraps;
    logic [PW-1:0] prev_gray;
    logic [AW-1:0] prev_addr;

    model_reset();
    #2 rrst_n = 1'b0;
    #1 check_all("reset_async");
    @(negedge rclk);
    rrst_n = 1'b1;

    // Sync latency: empty clears on the third edge after the write pointer moves.
    cyc(1'b0, 1'b1);
    chk("lat_edge1_rempty", 32'(rempty), 32'd1);
    cyc(1'b0, 1'b0);
    chk("lat_edge2_rempty", 32'(rempty), 32'd1);
    cyc(1'b0, 1'b0);
    chk("lat_edge3_rempty", 32'(rempty), 32'd0);
    cyc(1'b1, 1'b0);
    chk("rd1_raddr", 32'(raddr), 32'd1);
    chk("rd1_rptr_gray", 32'(rptr_gray), 32'b00001);
    chk("rd1_rempty", 32'(rempty), 32'd1);

    // Level from a fresh reset: five writes, then three reads.
    @(negedge rclk);
    rrst_n = 1'b0;
    rinc = 1'b0;
    wptr_gray = '0;
    model_reset();
    #1 check_all("reset2");
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("lvl5_rlevel", 32'(rlevel), LEVEL_EN ? 32'd5 : 32'd0);
    chk("lvl5_raempty", 32'(raempty), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    chk("lvl2_rlevel", 32'(rlevel), LEVEL_EN ? 32'd2 : 32'd0);
    chk("lvl2_raempty", 32'(raempty), LEVEL_EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0);
    chk("drained_rempty", 32'(rempty), 32'd1);

    // Underflow: two refused reads leave the pointer alone.
    cyc(1'b1, 1'b0);
    chk("uf1_pulse", 32'(runderflow), 32'd1);
    chk("uf1_raddr", 32'(raddr), 32'd5);
    cyc(1'b1, 1'b0);
    chk("uf2_pulse", 32'(runderflow), 32'd1);
    chk("uf2_rptr_gray", 32'(rptr_gray), 32'b00111);
    cyc(1'b0, 1'b0);
    chk("uf_clear", 32'(runderflow), 32'd0);

    // Random streaming across several pointer laps.
    gray_wraps = 0;
    addr_wraps = 0;
    for (int i = 0; i < 500; i++) begin
      prev_gray = rptr_gray;
      prev_addr = raddr;
      cyc(1'($urandom_range(0, 1)),
          ((wcnt - rcnt) < 15) && ($urandom_range(0, 3) != 0));
      if (prev_gray == 5'b10000 && rptr_gray == 5'b00000) gray_wraps++;
      if (prev_addr == 4'd15 && raddr == 4'd0) addr_wraps++;
    end
    chk("gray_wrap_seen", 32'(gray_wraps > 0), 32'd1);
    chk("addr_wrap_seen", 32'(addr_wraps > 1), 32'd1);

    // Settle at level 5, then reset mid-cycle.
    for (int i = 0; i < 80; i++) begin
      if (m_level == 5 && (wcnt - rcnt) == 5) break;
      cyc((wcnt - rcnt) > 5, (wcnt - rcnt) < 5);
    end
    chk("pre_reset_rlevel", 32'(rlevel), LEVEL_EN ? 32'd5 : 32'd0);
    chk("pre_reset_rempty", 32'(rempty), 32'd0);
    #2 rrst_n = 1'b0;
    model_reset();
    #1 check_all("reset_midop");
    rinc = 1'b0;
    wptr_gray = '0;
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("post_reset_uf", 32'(runderflow), 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/rd_ctrl_gray.md
RD_CTRL_GRAY -- requirements
Module: rd_ctrl_gray

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address bits; pointer width PW = ADDR_WIDTH+1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, write-pointer synchronizer depth, legal range 2..4.
REQ-003 SHALL have parameter AEMPTY_THRESH, default 4, almost-empty level threshold, legal range 0..2^ADDR_WIDTH.
REQ-004 SHALL have port rclk  input  1  read clock; the single clock; all flops on its rising edge.
REQ-005 SHALL have port rrst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port rinc  input  1  read request.
REQ-007 SHALL have port wptr_gray  input  PW  write pointer in Gray code, from the write domain, asynchronous to rclk.
REQ-008 SHALL have port rptr_gray  output  PW  registered read pointer in Gray code, for the write domain.
REQ-009 SHALL have port raddr  output  ADDR_WIDTH  RAM read address, low bits of the binary read pointer.
REQ-010 SHALL have port rempty  output  1  registered empty flag.
REQ-011 SHALL have port raempty  output  1  registered almost-empty flag.
REQ-012 SHALL have port rlevel  output  PW  registered occupancy as seen by the read domain.
REQ-013 SHALL have port runderflow  output  1  one-cycle pulse when a read is rejected.

Function
REQ-014 SHALL accept a read only when rinc=1 and rempty=0; an accepted read increments the binary pointer rbin by 1 modulo 2^PW.
REQ-015 SHALL register rptr_gray = rbin_next ^ (rbin_next>>1) in the same cycle that rbin updates; raddr = rbin[ADDR_WIDTH-1:0].
REQ-016 SHALL pass wptr_gray through SYNC_STAGES flops clocked by rclk to form wq_gray; no other logic SHALL sit between the stages.
REQ-017 SHALL register rempty = (rptr_gray_next == wq_gray), so rempty deasserts SYNC_STAGES+1 rclk edges after wptr_gray changes.
REQ-018 SHALL convert wq_gray to binary wq_bin and register rlevel = (wq_bin - rbin_next) mod 2^PW.
REQ-019 SHALL register raempty = (level_next <= AEMPTY_THRESH).
REQ-020 SHALL pulse runderflow=1 for exactly one cycle on the edge after rinc=1 while rempty=1; rbin, rptr_gray and raddr SHALL NOT change in that case.
REQ-021 SHALL wrap from rbin = 2^PW-1 to 0 with no special casing; the MSB difference distinguishes a full lap.
REQ-022 SHALL require wptr_gray to change by at most one bit per write-clock edge; behaviour under multi-bit changes is undefined.
REQ-023 SHALL keep each flag consistent within its cycle: rempty=1 implies rlevel=0.

Reset
REQ-024 SHALL, while rrst_n=0 and without a clock edge, force rbin=0, rptr_gray=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0 and all synchronizer stages to 0.
REQ-025 SHALL resume operation on the first rclk edge after rrst_n rises; an assertion of reset mid-operation SHALL discard all in-flight pointer state.

Configuration
REQ-026 SHALL compile level tracking in only when macro RD_CTRL_LEVEL_EN is defined: with it, the behaviour is REQ-018/019; without it, rlevel SHALL be tied to 0, raempty SHALL equal rempty, and no Gray-to-binary converter or subtractor SHALL be synthesized.

Structure
REQ-027 SHALL take bin2gray/gray2bin functions and the pointer-width computation from shared package fifo_pkg.
REQ-028 SHALL instantiate the synchronizer as sub-module sync_nff (parameters WIDTH, STAGES), reusable by the write side.

Verification (ADDR_WIDTH=4, SYNC_STAGES=2, AEMPTY_THRESH=2, RD_CTRL_LEVEL_EN defined)
REQ-029 SHALL check reset: rrst_n=0 mid-clock -> immediately rempty=1, raempty=1, rlevel=0, rptr_gray=00000, raddr=0, runderflow=0.
REQ-030 SHALL check latency: wptr_gray 00000->00001 -> rempty falls on 3rd rclk edge; one rinc -> raddr 0->1, rptr_gray=00001, rempty=1 next edge.
REQ-031 SHALL check level: wptr_gray=gray(5)=00111 -> rlevel=5, raempty=0; three reads -> rlevel=2, raempty=1.
REQ-032 SHALL check underflow: rinc=1 for 2 cycles while rempty=1 -> runderflow=1 for 2 cycles, raddr and rptr_gray unchanged.
REQ-033 SHALL check wrap: writer and reader stream past 31 -> rbin 31->0, raddr 15->0, rptr_gray 10000->00000, rempty only when pointers match.
REQ-034 SHALL check reset mid-operation: at rlevel=5 assert rrst_n=0 -> all outputs at REQ-024 values before the next edge.
